// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared types and defaults for the UART TX FIFO bridge
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } bridge_state_t;

    localparam logic [31:0] UART_TRIG_ADDR_DEF   = 32'd1600;
    localparam int          UART_FIFO_DEPTH_DEF  = 16;
    localparam int          UART_ACK_TIMEOUT_DEF = 15;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO that drops pushes arriving while full
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a push at full is accepted alongside it.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && !do_push;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_bridge.sv
// rtl/uart_tx_fifo_bridge.sv - queues core UART writes and paces loads into the transmitter
module uart_tx_fifo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int          DEPTH       = UART_FIFO_DEPTH_DEF,
    parameter logic [31:0] TRIG_ADDR   = UART_TRIG_ADDR_DEF,
    parameter int          ACK_TIMEOUT = UART_ACK_TIMEOUT_DEF,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   alu_out,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    input  logic          tx_busy,
    output logic          tx_load,
    output logic [7:0]    tx_data,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    input  logic          clr_overflow
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    bridge_state_t state;
    bridge_state_t state_nxt;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_nxt;
    logic          match;
    logic          match_q;
    logic          push;
    logic          pop;
    logic [7:0]    pop_data;
    logic          fifo_drop;

    // Only the first cycle of a (possibly long) store strobe enqueues a byte.
    assign match = (alu_out == TRIG_ADDR) && wr_valid;
    assign push  = match && !match_q;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = '0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A transmitter that never acknowledges still consumes the byte.
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            to_cnt   <= '0;
            match_q  <= 1'b0;
            tx_load  <= 1'b0;
            tx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            to_cnt   <= to_cnt_nxt;
            match_q  <= match;
            tx_load  <= pop;
            if (pop) begin
                tx_data <= pop_data;
            end
            overflow <= fifo_drop || (overflow && !clr_overflow);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_bridge.sv
// tb/tb_uart_tx_fifo_bridge.sv - scoreboard bench for uart_tx_fifo_bridge
module tb_uart_tx_fifo_bridge;

    localparam int DEPTH = 16;
    localparam int ACK   = 15;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   alu_out;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          tx_busy;
    logic          tx_load;
    logic [7:0]    tx_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          clr_overflow;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         load_cnt = 0;
    int         last_load_cyc = -1000;
    int         last_gap = 0;
    int         min_gap = 1000;
    logic       prev_load = 1'b0;
    logic [7:0] exp_b;
    logic [7:0] exp_q [$];
    int         model_mode = 0;
    int         busy_len = 3;
    int         busy_left = 0;

    uart_tx_fifo_bridge #(
        .DEPTH       (DEPTH),
        .TRIG_ADDR   (32'd1600),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alu_out      (alu_out),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .tx_busy      (tx_busy),
        .tx_load      (tx_load),
        .tx_data      (tx_data),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for busy_len cycles after each load.
    always @(negedge clk) begin
        if (model_mode == 1) begin
            if (tx_load === 1'b1) busy_left = busy_len;
            if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_load === 1'b1) begin
            checks++;
            if (prev_load) begin
                errors++;
                $display("FAIL load_width: tx_load=1 on consecutive cycles, required single-cycle pulse");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: tx_data=%h loaded, required no load", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL load_data: tx_data=%h, required %h", tx_data, exp_b);
                end
            end
            last_gap      = cyc - last_load_cyc;
            last_load_cyc = cyc;
            if (last_gap < min_gap) min_gap = last_gap;
            load_cnt++;
        end
        prev_load = (tx_load === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input bit accept);
        @(negedge clk);
        alu_out  = 32'd1600;
        wr_valid = 1'b1;
        wr_data  = b;
        if (accept) exp_q.push_back(b);
        repeat (hold) @(negedge clk);
        wr_valid = 1'b0;
        alu_out  = 32'd0;
    endtask

    task automatic wait_loads(input int target, input int budget);
        int n = 0;
        while (load_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (load_cnt < target) begin
            errors++;
            $display("FAIL load_timeout: loads=%0d, required %0d", load_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; alu_out = 32'd0; wr_valid = 1'b0; wr_data = 8'h00;
        tx_busy = 1'b0; clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL rst_load: %b, required 0", tx_load); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: %h, required 00", tx_data); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: %b, required 1", fifo_empty); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full: %b, required 0", fifo_full); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count: %0d, required 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: %b, required 0", overflow); end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        model_mode = 1; busy_len = 3;
        @(negedge clk);
        alu_out = 32'd1600; wr_valid = 1'b1; wr_data = 8'h41;
        exp_q.push_back(8'h41);
        @(negedge clk);
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count1: %0d, required 1", fifo_count); end
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL single_early: tx_load=%b, required 0", tx_load); end
        wr_valid = 1'b0; alu_out = 32'd0;
        @(negedge clk);
        checks++; if (tx_load !== 1'b1) begin errors++; $display("FAIL single_load: %b, required 1", tx_load); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data: %h, required 41", tx_data); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL single_count0: %0d, required 0", fifo_count); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty: %b, required 1", fifo_empty); end
        @(negedge clk);
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL single_pulse: %b, required 0", tx_load); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_held();
        int base = load_cnt;
        send_byte(8'h55, 5, 1'b1);
        repeat (25) @(negedge clk);
        checks++; if (load_cnt - base !== 1) begin errors++; $display("FAIL held_loads: %0d, required 1", load_cnt - base); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL held_pending: %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int base = load_cnt;
        busy_len = 10; min_gap = 1000;
        send_byte(8'h01, 1, 1'b1);
        send_byte(8'h02, 1, 1'b1);
        send_byte(8'h03, 1, 1'b1);
        wait_loads(base + 3, 200);
        checks++; if (min_gap < busy_len + 2) begin errors++; $display("FAIL burst_gap: %0d, required >= %0d", min_gap, busy_len + 2); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL burst_pending: %0d, required 0", exp_q.size()); end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_overflow();
        int base;
        model_mode = 0;
        @(negedge clk);
        tx_busy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h80 + 8'(i), 1, (i < DEPTH));
        @(negedge clk);
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: %b, required 1", fifo_full); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count: %0d, required 16", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: %b, required 1", overflow); end
        checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL ovf_empty: %b, required 0", fifo_empty); end
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: %b, required 0", overflow); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count_kept: %0d, required 16", fifo_count); end
        @(negedge clk);
        alu_out = 32'd1600; wr_valid = 1'b1; wr_data = 8'hEE; clr_overflow = 1'b1;
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_race: %b, required 1", overflow); end
        alu_out = 32'd0; wr_valid = 1'b0; clr_overflow = 1'b0;
        @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        base = load_cnt;
        alu_out = 32'd1600; wr_valid = 1'b1; wr_data = 8'hA0;
        exp_q.push_back(8'hA0);
        busy_len = 2; busy_left = 0; tx_busy = 1'b0; model_mode = 1;
        @(negedge clk);
        checks++; if (tx_load !== 1'b1) begin errors++; $display("FAIL full_pop: tx_load=%b, required 1", tx_load); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_pushpop_count: %0d, required 16", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: %b, required 0", overflow); end
        alu_out = 32'd0; wr_valid = 1'b0;
        wait_loads(base + DEPTH + 1, 400);
        repeat (10) @(negedge clk);
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: %b, required 1", fifo_empty); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL drain_pending: %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int base;
        model_mode = 0;
        @(negedge clk);
        tx_busy = 1'b0;
        base = load_cnt;
        send_byte(8'h11, 1, 1'b1);
        send_byte(8'h22, 1, 1'b1);
        wait_loads(base + 2, 80);
        checks++; if (last_gap !== ACK + 1) begin errors++; $display("FAIL timeout_gap: %0d, required %0d", last_gap, ACK + 1); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base;
        model_mode = 1; busy_len = 10;
        for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1, 1'b1);
        checks++; if (fifo_count !== 5'd4) begin errors++; $display("FAIL mid_count: %0d, required 4", fifo_count); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL mid_rst_load: %b, required 0", tx_load); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: %h, required 00", tx_data); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mid_rst_count: %0d, required 0", fifo_count); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty: %b, required 1", fifo_empty); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL mid_rst_full: %b, required 0", fifo_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf: %b, required 0", overflow); end
        model_mode = 0; busy_left = 0; tx_busy = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = load_cnt;
        repeat (30) @(negedge clk);
        checks++; if (load_cnt !== base) begin errors++; $display("FAIL mid_spurious: loads=%0d, required %0d", load_cnt, base); end
        model_mode = 1; busy_len = 3;
        send_byte(8'h77, 1, 1'b1);
        wait_loads(base + 1, 50);
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_pending: %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_bridge.md
# uart_tx_fifo_bridge

Buffers bytes written by the RISC-V core and feeds them one at a time to the UART transmitter controller. Sits between `RISC_V_Base_data_path` and `transmitter_controller` in the SoC top. It replaces the single-register trigger: back-to-back core writes to the UART address are queued rather than lost. It also paces `Load` strictly against the transmitter's `status` busy flag.

## Interface

Parameters:
- `DEPTH`, 16 — FIFO entries; power of two, ≥2.
- `TRIG_ADDR`, 32'd1600 — ALU result value that marks a UART write.
- `ACK_TIMEOUT`, 15 — maximum cycles to wait for `tx_busy` to rise after a load.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_out`  in  32  core ALU result (`ALU_OUT_check`).
- `wr_valid`  in  1  core store-qualify strobe (`signal`).
- `wr_data`  in  8  byte to send (`uart_reg`).
- `tx_busy`  in  1  transmitter `status`; 1 = frame in progress.
- `tx_load`  out  1  one-cycle load pulse to transmitter `Load`.
- `tx_data`  out  8  byte to transmitter `data_board`; stable from `tx_load` until the next load.
- `fifo_full`  out  1  FIFO holds `DEPTH` entries.
- `fifo_empty`  out  1  FIFO holds 0 entries.
- `fifo_count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky flag: a write was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation

- Match: `match = (alu_out == TRIG_ADDR) && wr_valid`. A push occurs only on a match rising edge (`match && !match_q`). A match held for several cycles pushes exactly one byte.
- Push while full: the byte is dropped, `overflow` is set and occupancy is unchanged.
- If `clr_overflow` and a new overflow occur in the same cycle, `overflow` stays 1.
- Pop and push in the same cycle: both take effect and the count is unchanged. This is legal at full because the pop frees a slot. The entry is decided before the push, so a push into an empty FIFO cannot be popped in the same cycle.
- Pointers wrap modulo `DEPTH`. Occupancy uses a separate counter in the range 0..DEPTH.
- FSM states:
  - IDLE: if `!fifo_empty && !tx_busy`, pop the head into `tx_data`, pulse `tx_load`, then go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_busy` = 1, go to WAIT_DONE. If `ACK_TIMEOUT` cycles elapse without it, go to IDLE; the byte is treated as sent and is not re-queued.
  - WAIT_DONE: when `tx_busy` = 0, go to IDLE.
- `tx_busy` high while in IDLE (for example, a transmitter started by another source) blocks the pop.
- Reset values: `tx_load` 0, `tx_data` 0, `fifo_empty` 1, `fifo_full` 0, `fifo_count` 0, `overflow` 0, FSM in IDLE, pointers 0, `match_q` 0, timeout counter 0.
- Reset mid-operation flushes the FIFO and drops any byte in flight.

## Timing

- All outputs are registered.
- A match rising edge sampled at clock edge E0 is written at E0, so `fifo_count` increments after E0.
- If the FSM is IDLE and `tx_busy` = 0, `tx_load` = 1 and `tx_data` is valid after E1, i.e. one cycle after the push.
- `tx_load` is high for exactly one cycle per byte.
- Minimum spacing between two `tx_load` pulses: 1 (LOAD) + at least 1 busy-high cycle + 1 (IDLE re-check).
- The FIFO pop and `fifo_count` decrement happen on the same edge that raises `tx_load`.
- `fifo_full` and `fifo_empty` update on the same edge as `fifo_count`.

## Structure

- Package `uart_bridge_pkg`:
  - `bridge_state_t` enum (IDLE, WAIT_BUSY, WAIT_DONE);
  - defaults `UART_TRIG_ADDR_DEF = 32'd1600` and `UART_FIFO_DEPTH_DEF = 16`.
- Sub-module `uart_sync_fifo`:
  - parameterised width and depth, same `clk`/`reset_n`;
  - push/pop/full/empty/count interface;
  - overflow drop is handled inside the FIFO.
- The top holds the match edge-detect, the FSM, the timeout counter and the `overflow` sticky register.

## Test plan

- Single write: `alu_out` = 1600, `wr_valid` = 1 for 1 cycle, `wr_data` = 8'h41, `tx_busy` = 0 → `tx_load` high for one cycle one cycle later, `tx_data` = 8'h41, `fifo_count` goes 1→0.
- Held match: match high for 5 cycles with `wr_data` = 8'h55 → exactly one push and one `tx_load`.
- Burst: 3 distinct match pulses (8'h01, 8'h02, 8'h03) while the transmitter model holds `tx_busy` for 10 cycles per byte → three loads in order 01, 02, 03. Each load occurs only after `tx_busy` has fallen.
- Overflow: `tx_busy` held at 1, 17 pushes with `DEPTH` = 16 → `fifo_full` = 1, `fifo_count` = 16, `overflow` = 1; `clr_overflow` then drops `overflow` to 0.
- Timeout: `tx_busy` never rises after a load → FSM returns to IDLE after 15 cycles and the next byte loads.
- Reset mid-burst: drop `reset_n` with 4 bytes queued and WAIT_DONE active → all outputs take their reset values immediately (asynchronous reset). No `tx_load` occurs after release until a new push.
